// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: five-digit BCD count (M:SS.hh) with start/stop/clear/lap control.
// Optional lap freeze display is built only when STOPWATCH_LAP_EN is defined.
//
// state | meaning
// IDLE  | stopped, count zero, waiting for start
// RUN   | counting, live count shown
// PAUSE | stopped, count and prescaler fraction held
// LAP   | counting, lap register shown (STOPWATCH_LAP_EN only)
module stopwatch_counter #(
   parameter int TICK_DIV = 1_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        lap,
   output logic [19:0] digits,
   output logic        running,
   output logic        frozen,
   output logic        wrap
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [19:0] FULL_SCALE = 20'h95999;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
`ifdef STOPWATCH_LAP_EN
      , LAP = 2'd3
`endif
   } state_t;

   state_t         state, state_next;
   logic [PW-1:0]  pre;
   logic [19:0]    count, count_inc;
   logic           counting, tick;
   logic           zero_pre, zero_cnt, capture;

`ifdef STOPWATCH_LAP_EN
   logic [19:0]    lap_reg;
   assign counting = (state == RUN) || (state == LAP);
   assign frozen   = (state == LAP);
   assign digits   = frozen ? lap_reg : count;
`else
   logic unused_lap;
   assign unused_lap = lap;
   assign counting   = (state == RUN);
   assign frozen     = 1'b0;
   assign digits     = count;
`endif

   assign running = counting;
   assign tick    = counting && (pre == PRE_MAX);

   // Ripple carry through the BCD digits; seconds tens wraps at 5.
   always_comb begin
      count_inc = count;
      if (count[3:0] != 4'd9) begin
         count_inc[3:0] = count[3:0] + 4'd1;
      end else begin
         count_inc[3:0] = 4'd0;
         if (count[7:4] != 4'd9) begin
            count_inc[7:4] = count[7:4] + 4'd1;
         end else begin
            count_inc[7:4] = 4'd0;
            if (count[11:8] != 4'd9) begin
               count_inc[11:8] = count[11:8] + 4'd1;
            end else begin
               count_inc[11:8] = 4'd0;
               if (count[15:12] != 4'd5) begin
                  count_inc[15:12] = count[15:12] + 4'd1;
               end else begin
                  count_inc[15:12] = 4'd0;
                  count_inc[19:16] = (count[19:16] == 4'd9) ? 4'd0 : count[19:16] + 4'd1;
               end
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      zero_pre   = 1'b0;
      zero_cnt   = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (start_stop && !clear) begin
               state_next = RUN;
               zero_pre   = 1'b1;
            end
         end
         RUN: begin
            if (start_stop) begin
               state_next = PAUSE;
`ifdef STOPWATCH_LAP_EN
            end else if (lap) begin
               state_next = LAP;
               capture    = 1'b1;
`endif
            end
         end
         PAUSE: begin
            if (clear) begin
               state_next = IDLE;
               zero_pre   = 1'b1;
               zero_cnt   = 1'b1;
            end else if (start_stop) begin
               state_next = RUN;
            end
         end
`ifdef STOPWATCH_LAP_EN
         LAP: begin
            if (start_stop) begin
               state_next = PAUSE;
            end else if (lap) begin
               state_next = RUN;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         pre   <= '0;
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         state <= state_next;
         wrap  <= tick && (count == FULL_SCALE);
         if (zero_pre) begin
            pre <= '0;
         end else if (counting) begin
            pre <= tick ? '0 : pre + 1'b1;
         end
         if (zero_cnt) begin
            count <= '0;
         end else if (tick) begin
            count <= count_inc;
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   // Capture the value written at the lap edge, including a coincident tick.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lap_reg <= '0;
      end else if (capture) begin
         lap_reg <= tick ? count_inc : count;
      end
   end
`endif

endmodule
